i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_pkg.sv | 14 +
 rtl/sync_edge.sv | 31 +++
 rtl/i2s_rx.sv | 157 +++++++++++++++
 tb/tb_i2s_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S receiver.
// Imported by i2s_rx and sync_edge.
package i2s_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with rising-edge detect on the synced value.
// Used for bclk, and at equal depth for l_r_clk and sdata to keep them aligned.
module sync_edge
    import i2s_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] ff;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff   <= '0;
            prev <= 1'b0;
        end else begin
            ff   <= {ff[STAGES-2:0], din};
            prev <= ff[STAGES-1];
        end
    end

    assign sync = ff[STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: captures DATA_W MSBs of each slot, one-bit-delayed framing.
// Define I2S_RX_ERR_EN to add the frame_err short-word pulse output.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bclk,
    input  logic                     l_r_clk,
    input  logic                     sdata,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_ch,
    output logic                     sample_valid
`ifdef I2S_RX_ERR_EN
    ,
    output logic                     frame_err
`endif
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic b_rise;
    logic lr_s;
    logic sd_s;
    logic unused_b_sync;
    logic unused_lr_rise;
    logic unused_sd_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk   (clk),
        .reset (reset),
        .din   (bclk),
        .sync  (unused_b_sync),
        .rise  (b_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_lr (
        .clk   (clk),
        .reset (reset),
        .din   (l_r_clk),
        .sync  (lr_s),
        .rise  (unused_lr_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sd (
        .clk   (clk),
        .reset (reset),
        .din   (sdata),
        .sync  (sd_s),
        .rise  (unused_sd_rise)
    );

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              word_ch, ch_n;
    logic              last_lr, last_n;
    logic              done, done_n;
    logic              short_word;
    logic              lr_chg;

    assign lr_chg = lr_s ^ last_lr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            word_ch <= 1'b0;
            last_lr <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            word_ch <= ch_n;
            last_lr <= last_n;
            done    <= done_n;
        end
    end

    // Every decision is gated by a synced bclk rise; raw pins never steer the FSM.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        ch_n       = word_ch;
        last_n     = last_lr;
        done_n     = 1'b0;
        short_word = 1'b0;
        if (b_rise) begin
            last_n = lr_s;
            unique case (state)
                IDLE: begin
                    if (lr_chg) state_n = SKIP;
                end
                SKIP: begin
                    if (!lr_chg) begin
                        shreg_n = {shreg[DATA_W-2:0], sd_s};
                        cnt_n   = CW'(1);
                        ch_n    = lr_s;
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (lr_chg) begin
                        short_word = 1'b1;
                        cnt_n      = '0;
                        state_n    = SKIP;
                    end else begin
                        shreg_n = {shreg[DATA_W-2:0], sd_s};
                        cnt_n   = cnt + CW'(1);
                        if (cnt == LAST) begin
                            done_n  = 1'b1;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (lr_chg) begin
                        cnt_n   = '0;
                        state_n = SKIP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out   <= '0;
            sample_ch    <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= done;
            if (done) begin
                sample_out <= shreg;
                sample_ch  <= word_ch;
            end
        end
    end

`ifdef I2S_RX_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_err <= 1'b0;
        else        frame_err <= short_word;
    end
`else
    logic unused_short;
    assign unused_short = short_word;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: I2S frames in, queued expected words out.
// Honours I2S_RX_ERR_EN for the frame_err port.
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int      DW = 16;
    localparam int      SS = 2;
    localparam realtime HB = 163.0;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic bclk    = 1'b0;
    logic l_r_clk = 1'b1;
    logic sdata   = 1'b0;

    logic [DW-1:0] sample_out;
    logic          sample_ch;
    logic          sample_valid;
`ifdef I2S_RX_ERR_EN
    logic          frame_err;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ch;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            n_pulse = 0;
    int            n_push  = 0;
    int            n_err   = 0;
    int            exp_err = 0;
    int            edges   = 0;
    bit            track   = 0;
    bit            prev_v  = 0;
    logic          carry   = 1'b0;
    logic [DW-1:0] last_d  = '0;
    logic [DW-1:0] vals [32];

    always #10 clk = ~clk;

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .l_r_clk      (l_r_clk),
        .sdata        (sdata),
        .sample_out   (sample_out),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid)
`ifdef I2S_RX_ERR_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (track) edges++;

    always @(negedge clk) begin
        if (sample_valid) begin
            check("valid_width", 32'(prev_v), 0);
            n_pulse++;
            if (sb.size() == 0) begin
                check("extra_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check("data", 32'(sample_out), 32'(e.d));
                check("ch", 32'(sample_ch), 32'(e.ch));
                last_d = e.d;
            end
            check("latency", edges, SS + 2);
            track = 0;
        end
        prev_v = sample_valid;
`ifdef I2S_RX_ERR_EN
        if (frame_err) n_err++;
`endif
    end

    task automatic send_bit(logic lr, logic d, bit mark);
        bclk    = 1'b0;
        l_r_clk = lr;
        sdata   = d;
        #(HB);
        bclk = 1'b1;
        if (mark) begin
            edges = 0;
            track = 1;
        end
        #(HB);
    endtask

    // One slot of nb bclks; data lags word select by one bclk.
    task automatic send_slot(logic lr, logic [31:0] w, int nb, int rst_at);
        logic [63:0] b = {w, 32'h0};
        bit full = (nb - 1 >= DW) && (rst_at < 0);
        if (full) begin
            sb.push_back('{d: w[31:32-DW], ch: lr});
            n_push++;
        end
        if (nb - 1 < DW && nb > 1 && rst_at < 0) exp_err++;
        for (int j = 0; j < nb; j++) begin
            logic bv = (j == 0) ? carry : b[64-j];
            send_bit(lr, bv, full && (j == DW));
            if (j == rst_at) begin
                check("hold_data", 32'(sample_out), 32'(last_d));
                reset = 1'b0;
                #1;
                check("rst_data", 32'(sample_out), 0);
                check("rst_ch", 32'(sample_ch), 0);
                check("rst_valid", 32'(sample_valid), 0);
            end
            if (rst_at >= 0 && j == rst_at + 1) reset = 1'b1;
        end
        carry = b[64-nb];
    endtask

    initial begin
        #1.3;
        check("rst_data0", 32'(sample_out), 0);
        check("rst_ch0", 32'(sample_ch), 0);
        check("rst_valid0", 32'(sample_valid), 0);
`ifdef I2S_RX_ERR_EN
        check("rst_ferr0", 32'(frame_err), 0);
`endif
        #50 reset = 1'b1;

        send_slot(1'b1, 32'h0000_0000, 32, -1);
        send_slot(1'b0, 32'h4000_0000, 32, -1);
        send_slot(1'b1, 32'hE000_0000, 32, -1);
        send_slot(1'b0, 32'h1234_5600, 32, -1);
        send_slot(1'b1, 32'hABCD_0000, 32, -1);
        send_slot(1'b0, 32'hFFFF_0000, 8, -1);
        send_slot(1'b1, 32'h7FFF_0000, 32, -1);

        for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
        vals[0]  = 16'h8000;
        vals[1]  = 16'h7FFF;
        vals[2]  = 16'h0000;
        vals[3]  = 16'hFFFF;
        vals[10] = 16'h0001;
        vals[21] = 16'hFFFE;
        for (int i = 0; i < 32; i++) begin
            send_slot(1'(i % 2), {vals[i], 16'h0}, 32, -1);
        end

        send_slot(1'b0, 32'h1111_0000, 32, 8);
        send_slot(1'b1, 32'h2468_0000, 32, -1);
        send_slot(1'b0, 32'h1357_0000, 32, -1);
        send_slot(1'b1, 32'h0F0F_0000, 32, -1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        check("pulses", n_pulse, n_push);
`ifdef I2S_RX_ERR_EN
        check("frame_err_cnt", n_err, exp_err);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
